// File: rtl/flight_cmd_sequencer.sv
// Script player for the RemoteComm host link. It sends each stored command and waits for the ACK.
// Where an entry asks for it, it then settles and checks one flight channel against the commanded value.
module flight_cmd_sequencer #(
  parameter int         DEPTH  = 16,
  parameter int         NCHAN  = 4,
  parameter int         ACK_TO = 2000000,
  parameter int         SETTLE = 2000000,
  parameter int         CHK_TO = 10000000,
  parameter int         TOL    = 5,
  parameter int         TW     = 24,
  parameter logic [7:0] ACK    = 8'hA5,
  localparam int        AW     = $clog2(DEPTH),
  localparam int        CW     = $clog2(NCHAN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW:0]           len,
  input  logic                  ld_we,
  input  logic [AW-1:0]         ld_addr,
  input  logic [7:0]            ld_cmd,
  input  logic [15:0]           ld_data,
  input  logic                  ld_chk_en,
  input  logic [CW-1:0]         ld_chk_sel,
  output logic [7:0]            cmd,
  output logic [15:0]           data,
  output logic                  send_cmd,
  input  logic                  cmd_sent,
  input  logic                  resp_rdy,
  input  logic [7:0]            resp,
  output logic                  clr_resp_rdy,
  input  logic [NCHAN*16-1:0]   mon,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2:0]            err_code,
  output logic [AW-1:0]         err_idx,
  output logic [AW:0]           pass_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_SEND, ST_WAIT_RESP, ST_SETTLE, ST_CHECK, ST_DONE
  } state_t;

  localparam logic [2:0]    ERR_NONE     = 3'd0;
  localparam logic [2:0]    ERR_ACK_TO   = 3'd1;
  localparam logic [2:0]    ERR_BAD_RESP = 3'd2;
  localparam logic [2:0]    ERR_CHK_TO   = 3'd3;
  localparam logic [2:0]    ERR_EMPTY    = 3'd4;
  localparam logic [AW:0]   DEPTH_LEN    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT      = (AW+1)'(1);
  localparam logic [TW-1:0] ACK_LIM      = TW'(ACK_TO);
  localparam logic [TW-1:0] SETTLE_LIM   = TW'(SETTLE);
  localparam logic [TW-1:0] CHK_LIM      = TW'(CHK_TO);

  logic [7:0]    mem_cmd    [DEPTH];
  logic [15:0]   mem_data   [DEPTH];
  logic          mem_chk_en [DEPTH];
  logic [CW-1:0] mem_chk_sel[DEPTH];

  state_t        state_reg;
  logic [AW:0]   len_reg;
  logic [AW:0]   idx_reg;
  logic [TW-1:0] timer_reg;
  logic          chk_en_reg;
  logic [CW-1:0] chk_sel_reg;

  logic [15:0]   mon_ch [NCHAN];
  logic [15:0]   chan_val;
  logic [16:0]   diff;
  logic [16:0]   abs_diff;
  logic          within_tol;
  logic [TW-1:0] timer_inc;
  logic [AW:0]   idx_next;
  logic          entry_ok;
  logic          entry_fail;
  logic [2:0]    fail_code;
  logic          unused_cmd_sent;

  assign unused_cmd_sent = cmd_sent;

  generate
    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_unpack
      assign mon_ch[gi] = mon[16*gi +: 16];
    end
  endgenerate

  // Both operands are sign-extended to 17 bits so the difference can never wrap.
  assign chan_val   = mon_ch[chk_sel_reg];
  assign diff       = {chan_val[15], chan_val} - {data[15], data};
  assign abs_diff   = diff[16] ? (~diff + 17'd1) : diff;
  assign within_tol = (abs_diff <= 17'(TOL));
  assign timer_inc  = timer_reg + TW'(1);
  assign idx_next   = idx_reg + ONE_CNT;

  always_ff @(posedge clk) begin
    if (ld_we && !busy) begin
      mem_cmd[ld_addr]     <= ld_cmd;
      mem_data[ld_addr]    <= ld_data;
      mem_chk_en[ld_addr]  <= ld_chk_en;
      mem_chk_sel[ld_addr] <= ld_chk_sel;
    end
  end

  // A response arriving on the limit cycle is evaluated first, so it wins over the timeout.
  always_comb begin
    entry_ok   = 1'b0;
    entry_fail = 1'b0;
    fail_code  = ERR_NONE;
    case (state_reg)
      ST_WAIT_RESP: begin
        if (resp_rdy) begin
          if (resp == ACK) begin
            entry_ok = !chk_en_reg;
          end else begin
            entry_fail = 1'b1;
            fail_code  = ERR_BAD_RESP;
          end
        end else if (timer_inc == ACK_LIM) begin
          entry_fail = 1'b1;
          fail_code  = ERR_ACK_TO;
        end
      end
      ST_CHECK: begin
        if (within_tol) begin
          entry_ok = 1'b1;
        end else if (timer_inc == CHK_LIM) begin
          entry_fail = 1'b1;
          fail_code  = ERR_CHK_TO;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      len_reg      <= '0;
      idx_reg      <= '0;
      timer_reg    <= '0;
      chk_en_reg   <= 1'b0;
      chk_sel_reg  <= '0;
      cmd          <= '0;
      data         <= '0;
      send_cmd     <= 1'b0;
      clr_resp_rdy <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_code     <= ERR_NONE;
      err_idx      <= '0;
      pass_cnt     <= '0;
    end else begin
      send_cmd     <= 1'b0;
      // Single clear pulse per response, even if the flag is still up the cycle after.
      clr_resp_rdy <= resp_rdy && !clr_resp_rdy;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            pass_cnt <= '0;
            err_idx  <= '0;
            pass     <= 1'b0;
            if (len == '0) begin
              done      <= 1'b1;
              err_code  <= ERR_EMPTY;
              state_reg <= ST_DONE;
            end else begin
              len_reg   <= (len > DEPTH_LEN) ? DEPTH_LEN : len;
              idx_reg   <= '0;
              done      <= 1'b0;
              err_code  <= ERR_NONE;
              busy      <= 1'b1;
              state_reg <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          cmd         <= mem_cmd[idx_reg[AW-1:0]];
          data        <= mem_data[idx_reg[AW-1:0]];
          chk_en_reg  <= mem_chk_en[idx_reg[AW-1:0]];
          chk_sel_reg <= mem_chk_sel[idx_reg[AW-1:0]];
          send_cmd    <= 1'b1;
          timer_reg   <= '0;
          state_reg   <= ST_SEND;
        end
        ST_SEND: begin
          timer_reg <= timer_inc;
          state_reg <= ST_WAIT_RESP;
        end
        ST_WAIT_RESP: begin
          if (resp_rdy && resp == ACK && chk_en_reg) begin
            timer_reg <= '0;
            state_reg <= ST_SETTLE;
          end else begin
            timer_reg <= timer_inc;
          end
        end
        ST_SETTLE: begin
          if (timer_inc == SETTLE_LIM) begin
            timer_reg <= '0;
            state_reg <= ST_CHECK;
          end else begin
            timer_reg <= timer_inc;
          end
        end
        ST_CHECK: timer_reg <= timer_inc;
        default:  state_reg <= ST_IDLE;
      endcase

      if (entry_ok) begin
        pass_cnt <= pass_cnt + ONE_CNT;
        idx_reg  <= idx_next;
        if (idx_next == len_reg) begin
          busy      <= 1'b0;
          done      <= 1'b1;
          pass      <= 1'b1;
          state_reg <= ST_DONE;
        end else begin
          state_reg <= ST_FETCH;
        end
      end
      if (entry_fail) begin
        err_idx   <= idx_reg[AW-1:0];
        err_code  <= fail_code;
        busy      <= 1'b0;
        done      <= 1'b1;
        pass      <= 1'b0;
        state_reg <= ST_DONE;
      end
    end
  end

endmodule

// File: tb/tb_flight_cmd_sequencer.sv
// Bench for flight_cmd_sequencer: a RemoteComm responder model, and scoreboard queues of expected sends and results.
module tb_flight_cmd_sequencer;
  localparam int DEPTH  = 16;
  localparam int NCHAN  = 4;
  localparam int AW     = 4;
  localparam int CW     = 2;
  localparam int ACK_TO = 200;
  localparam int SETTLE = 50;
  localparam int CHK_TO = 500;
  localparam int RD     = 3;

  typedef struct packed { logic [7:0] cmd; logic [15:0] data; } cmd_t;
  typedef struct packed { logic pass; logic [2:0] code; logic [AW-1:0] idx; logic [AW:0] cnt; } res_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ld_we = 1'b0, ld_chk_en = 1'b0;
  logic [AW:0] len = '0;
  logic [AW-1:0] ld_addr = '0;
  logic [7:0] ld_cmd = '0, resp = '0;
  logic [15:0] ld_data = '0;
  logic [CW-1:0] ld_chk_sel = '0;
  logic cmd_sent = 1'b0, resp_rdy = 1'b0;
  logic [15:0] ch_ptch = '0, ch_roll = '0, ch_yaw = '0, ch_thrst = '0;
  logic [NCHAN*16-1:0] mon;
  logic [7:0] cmd;
  logic [15:0] data;
  logic send_cmd, clr_resp_rdy, busy, done, pass;
  logic [2:0] err_code;
  logic [AW-1:0] err_idx;
  logic [AW:0] pass_cnt;

  cmd_t cmd_q[$];
  res_t res_q[$];
  int checks = 0, errors = 0, cyc = 0;
  int sends, clrs, first_send_cyc, last_send_cyc, start_cyc, done_cyc, rsp_count;
  bit silent_en = 0, bad_en = 0;
  int silent_idx = 0, bad_idx = 0;

  assign mon = {ch_thrst, ch_yaw, ch_roll, ch_ptch};

  flight_cmd_sequencer #(
    .DEPTH(DEPTH), .NCHAN(NCHAN), .ACK_TO(ACK_TO), .SETTLE(SETTLE), .CHK_TO(CHK_TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_cmd(ld_cmd), .ld_data(ld_data),
    .ld_chk_en(ld_chk_en), .ld_chk_sel(ld_chk_sel),
    .cmd(cmd), .data(data), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
    .resp_rdy(resp_rdy), .resp(resp), .clr_resp_rdy(clr_resp_rdy), .mon(mon),
    .busy(busy), .done(done), .pass(pass), .err_code(err_code),
    .err_idx(err_idx), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin : monitor
    cmd_t e;
    forever begin
      @(negedge clk);
      if (send_cmd) begin
        sends++;
        last_send_cyc = cyc;
        if (first_send_cyc < 0) first_send_cyc = cyc;
        check_val("send_expected", cmd_q.size() > 0, 1);
        if (cmd_q.size() > 0) begin
          e = cmd_q.pop_front();
          check_val("send_cmd_byte", cmd, e.cmd);
          check_val("send_data", data, e.data);
        end
      end
      if (clr_resp_rdy) clrs++;
    end
  end

  // RemoteComm model: answers RD cycles after each send and holds resp_rdy until cleared.
  initial begin : responder
    int k;
    forever begin
      @(negedge clk);
      if (send_cmd && !rst) begin
        k = rsp_count;
        rsp_count++;
        if (!(silent_en && k == silent_idx)) begin
          repeat (RD) @(negedge clk);
          resp = (bad_en && k == bad_idx) ? 8'hFF : 8'hA5;
          resp_rdy = 1'b1;
          for (int w = 0; w < 20 && !clr_resp_rdy; w++) @(negedge clk);
          resp_rdy = 1'b0;
        end
      end
    end
  end

  task automatic load_entry(input int a, input logic [7:0] c, input logic [15:0] d,
                            input logic en, input logic [CW-1:0] sel);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = AW'(a); ld_cmd = c; ld_data = d; ld_chk_en = en; ld_chk_sel = sel;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic expect_cmd(input logic [7:0] c, input logic [15:0] d);
    cmd_q.push_back({c, d});
  endtask

  task automatic expect_res(input logic p, input logic [2:0] code, input logic [AW-1:0] idx,
                            input logic [AW:0] cnt);
    res_q.push_back({p, code, idx, cnt});
  endtask

  task automatic run(input string tag, input logic [AW:0] l, input int budget);
    res_t r;
    sends = 0; clrs = 0; rsp_count = 0; first_send_cyc = -1;
    @(negedge clk);
    start = 1'b1; len = l; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    done_cyc = cyc;
    check_val({tag, "/done"}, done, 1);
    check_val({tag, "/busy"}, busy, 0);
    if (res_q.size() > 0) begin
      r = res_q.pop_front();
      check_val({tag, "/pass"}, pass, r.pass);
      check_val({tag, "/err_code"}, err_code, r.code);
      check_val({tag, "/pass_cnt"}, pass_cnt, r.cnt);
      if (r.code != 3'd0) check_val({tag, "/err_idx"}, err_idx, r.idx);
    end
    check_val({tag, "/cmd_q_empty"}, cmd_q.size(), 0);
    cmd_q.delete();
    $display("run %s: pass=%0d err_code=%0d err_idx=%0d pass_cnt=%0d sends=%0d clrs=%0d cycles=%0d",
             tag, pass, err_code, err_idx, pass_cnt, sends, clrs, done_cyc - start_cyc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "/cmd"}, cmd, 0);
    check_val({tag, "/data"}, data, 0);
    check_val({tag, "/send_cmd"}, send_cmd, 0);
    check_val({tag, "/clr_resp_rdy"}, clr_resp_rdy, 0);
    check_val({tag, "/busy"}, busy, 0);
    check_val({tag, "/done"}, done, 0);
    check_val({tag, "/pass"}, pass, 0);
    check_val({tag, "/err_code"}, err_code, 0);
    check_val({tag, "/err_idx"}, err_idx, 0);
    check_val({tag, "/pass_cnt"}, pass_cnt, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Empty script: done with code 4 one cycle after start.
    @(negedge clk);
    start = 1'b1; len = '0;
    @(negedge clk);
    start = 1'b0;
    check_val("empty/done", done, 1);
    check_val("empty/err_code", err_code, 4);
    check_val("empty/pass", pass, 0);
    check_val("empty/busy", busy, 0);
    $display("run empty: done=%0d err_code=%0d", done, err_code);

    // Three-entry script, all passing.
    ch_ptch = 16'hFFF2; ch_thrst = 16'h0100;
    load_entry(0, 8'h06, 16'h0000, 1'b0, 2'd0);
    load_entry(1, 8'h05, 16'h00FF, 1'b1, 2'd3);
    load_entry(2, 8'h02, 16'hFFF0, 1'b1, 2'd0);
    expect_cmd(8'h06, 16'h0000); expect_cmd(8'h05, 16'h00FF); expect_cmd(8'h02, 16'hFFF0);
    expect_res(1'b1, 3'd0, '0, 5'd3);
    run("script3", 5'd3, 1000);
    check_val("script3/start_to_send", first_send_cyc - start_cyc, 2);
    check_val("script3/sends", sends, 3);
    check_val("script3/clrs", clrs, 3);

    // Responder silent on entry 1.
    silent_en = 1; silent_idx = 1;
    expect_cmd(8'h06, 16'h0000); expect_cmd(8'h05, 16'h00FF);
    expect_res(1'b0, 3'd1, 4'd1, 5'd1);
    run("ack_timeout", 5'd3, 1000);
    silent_en = 0;
    check_val("ack_timeout/latency", done_cyc - last_send_cyc, ACK_TO);
    check_val("ack_timeout/sends", sends, 2);

    // Bad response byte on entry 0.
    bad_en = 1; bad_idx = 0;
    expect_cmd(8'h06, 16'h0000);
    expect_res(1'b0, 3'd2, 4'd0, 5'd0);
    run("bad_resp", 5'd3, 1000);
    bad_en = 0;
    check_val("bad_resp/clrs", clrs, 1);
    check_val("bad_resp/sends", sends, 1);

    // Roll tolerance: 6 off fails, 5 off passes.
    load_entry(0, 8'h07, 16'h0100, 1'b1, 2'd1);
    ch_roll = 16'h0106;
    expect_cmd(8'h07, 16'h0100);
    expect_res(1'b0, 3'd3, 4'd0, 5'd0);
    run("roll_off6", 5'd1, 2000);
    check_val("roll_off6/latency", done_cyc - last_send_cyc, RD + 1 + SETTLE + CHK_TO);

    ch_roll = 16'h0105;
    expect_cmd(8'h07, 16'h0100);
    expect_res(1'b1, 3'd0, '0, 5'd1);
    run("roll_off5", 5'd1, 2000);
    check_val("roll_off5/latency", done_cyc - last_send_cyc, RD + 1 + SETTLE + 1);

    // -32768 vs 32767 is 65535 apart, not -1.
    load_entry(0, 8'h07, 16'h8000, 1'b1, 2'd1);
    ch_roll = 16'h7FFF;
    expect_cmd(8'h07, 16'h8000);
    expect_res(1'b0, 3'd3, 4'd0, 5'd0);
    run("no_wrap", 5'd1, 2000);

    // Script write attempted mid-run must be ignored.
    load_entry(0, 8'h07, 16'h0100, 1'b1, 2'd1);
    ch_roll = 16'h0105;
    expect_cmd(8'h07, 16'h0100);
    expect_res(1'b1, 3'd0, '0, 5'd1);
    fork
      run("ld_busy_a", 5'd1, 1000);
      begin
        repeat (4) @(negedge clk);
        check_val("ld_busy/busy_during_write", busy, 1);
        load_entry(0, 8'h33, 16'h1234, 1'b0, 2'd0);
      end
    join
    expect_cmd(8'h07, 16'h0100);
    expect_res(1'b1, 3'd0, '0, 5'd1);
    run("ld_busy_b", 5'd1, 1000);

    // Reset during SETTLE.
    expect_cmd(8'h07, 16'h0100);
    sends = 0; clrs = 0; rsp_count = 0; first_send_cyc = -1;
    @(negedge clk);
    start = 1'b1; len = 5'd1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && clrs == 0; i++) @(negedge clk);
    check_val("rst_settle/ack_seen", clrs, 1);
    repeat (10) @(negedge clk);
    check_val("rst_settle/busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_settle");
    rst = 1'b0;
    check_val("rst_settle/cmd_q_empty", cmd_q.size(), 0);
    $display("run rst_settle: busy=%0d cmd=%0h data=%0h", busy, cmd, data);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
